// File: rtl/cp0_irq_if.sv
// CPU-side bus of the coprocessor-0 block.
// The external interrupt lines are carried here as well.
interface cp0_irq_if #(
  parameter int IRQ_NUM = 5
) ();
  logic               mfc0;
  logic               mtc0;
  logic [31:0]        pc;
  logic [4:0]         Rd;
  logic [31:0]        wdata;
  logic               exception;
  logic               eret;
  logic [4:0]         cause;
  logic [IRQ_NUM-1:0] irq;
  logic [31:0]        rdata;
  logic [31:0]        status;
  logic [31:0]        exc_addr;
  logic               irq_pending;

  modport master (
    output mfc0, mtc0, pc, Rd, wdata, exception, eret, cause, irq,
    input  rdata, status, exc_addr, irq_pending
  );

  modport slave (
    input  mfc0, mtc0, pc, Rd, wdata, exception, eret, cause, irq,
    output rdata, status, exc_addr, irq_pending
  );
endinterface

// File: rtl/cp0_irq.sv
// Coprocessor 0 for the multi-cycle MIPS core.
// Adds a Count/Compare timer, synchronised external interrupts and masking.
module cp0_irq #(
  parameter int          IRQ_NUM    = 5,
  parameter int          COUNT_DIV  = 2,
  parameter logic [31:0] EXC_VECTOR = 32'h00400004
) (
  input  logic        clk,
  input  logic        reset,
  cp0_irq_if.slave    bus
);
  localparam logic [4:0] REG_COUNT   = 5'd9;
  localparam logic [4:0] REG_COMPARE = 5'd11;
  localparam logic [4:0] REG_STATUS  = 5'd12;
  localparam logic [4:0] REG_CAUSE   = 5'd13;
  localparam logic [4:0] REG_EPC     = 5'd14;
  localparam logic [7:0] PRESC_LAST  = 8'(COUNT_DIV - 1);

  logic [31:0]        count_q;
  logic [31:0]        compare_q;
  logic [31:0]        epc_q;
  logic [7:0]         im_q;
  logic               exl_q;
  logic               ie_q;
  logic [1:0]         ip_sw_q;
  logic               ip_timer_q;
  logic [4:0]         exc_code_q;
  logic [7:0]         presc_q;
  logic [IRQ_NUM-1:0] sync1_q;
  logic [IRQ_NUM-1:0] sync2_q;

  logic [4:0]  ip_hw;
  logic [7:0]  ip;
  logic [31:0] status_val;
  logic [31:0] cause_val;
  logic        wr_en;
  logic        count_ld;
  logic        compare_wr;
  logic        presc_wrap;
  logic        tick;
  logic [31:0] count_inc;
  logic        match;

  always_comb begin
    ip_hw = '0;
    ip_hw[IRQ_NUM-1:0] = sync2_q;
  end

  assign ip         = {ip_timer_q, ip_hw, ip_sw_q};
  assign status_val = {16'h0000, im_q, 6'b000000, exl_q, ie_q};
  assign cause_val  = {16'h0000, ip, 1'b0, exc_code_q, 2'b00};

  // exception and eret both outrank a register write in the same cycle
  assign wr_en      = bus.mtc0 && !bus.exception && !bus.eret;
  assign count_ld   = wr_en && (bus.Rd == REG_COUNT);
  assign compare_wr = wr_en && (bus.Rd == REG_COMPARE);
  assign presc_wrap = (presc_q == PRESC_LAST);
  assign tick       = presc_wrap && !count_ld;
  assign count_inc  = count_q + 32'd1;
  assign match      = tick && (count_inc == compare_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q    <= '0;
      compare_q  <= 32'hFFFF_FFFF;
      epc_q      <= '0;
      im_q       <= '0;
      exl_q      <= 1'b0;
      ie_q       <= 1'b0;
      ip_sw_q    <= '0;
      ip_timer_q <= 1'b0;
      exc_code_q <= '0;
      presc_q    <= '0;
      sync1_q    <= '0;
      sync2_q    <= '0;
    end else begin
      sync1_q <= bus.irq;
      sync2_q <= sync1_q;

      presc_q <= (count_ld || presc_wrap) ? 8'd0 : presc_q + 8'd1;

      if (count_ld)
        count_q <= bus.wdata;
      else if (tick)
        count_q <= count_inc;

      if (compare_wr)
        compare_q <= bus.wdata;

      // a Compare write acknowledges the timer even if a match lands this cycle
      if (compare_wr)
        ip_timer_q <= 1'b0;
      else if (match)
        ip_timer_q <= 1'b1;

      if (bus.exception) begin
        epc_q      <= bus.pc;
        exc_code_q <= bus.cause;
        exl_q      <= 1'b1;
      end else if (bus.eret) begin
        exl_q <= 1'b0;
      end else if (wr_en) begin
        case (bus.Rd)
          REG_STATUS: begin
            im_q  <= bus.wdata[15:8];
            exl_q <= bus.wdata[1];
            ie_q  <= bus.wdata[0];
          end
          REG_CAUSE: ip_sw_q <= bus.wdata[9:8];
          REG_EPC:   epc_q   <= bus.wdata;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    bus.rdata = '0;
    if (bus.mfc0) begin
      case (bus.Rd)
        REG_COUNT:   bus.rdata = count_q;
        REG_COMPARE: bus.rdata = compare_q;
        REG_STATUS:  bus.rdata = status_val;
        REG_CAUSE:   bus.rdata = cause_val;
        REG_EPC:     bus.rdata = epc_q;
        default:     bus.rdata = '0;
      endcase
    end
  end

  assign bus.status      = status_val;
  assign bus.exc_addr    = (bus.eret && !bus.exception) ? epc_q : EXC_VECTOR;
  assign bus.irq_pending = ie_q && !exl_q && |(ip & im_q);

endmodule

// File: tb/tb_cp0_irq.sv
// Scoreboard bench for cp0_irq: expectations queued at stimulus, checked at sample.
module tb_cp0_irq;
  localparam logic [31:0] VEC = 32'h00400004;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #10 clk = ~clk;

  cp0_irq_if #(.IRQ_NUM(5)) bus ();

  cp0_irq #(
    .IRQ_NUM   (5),
    .COUNT_DIV (2),
    .EXC_VECTOR(VEC)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct {
    string       tag;
    logic [31:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [31:0] exp);
    exp_t e;
    e.tag = tag;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic sb_pop(input logic [31:0] obs);
    exp_t e;
    if (sb_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL sb_empty: got no expectation for observed %h", obs);
    end else begin
      e = sb_q.pop_front();
      chk(e.tag, obs, e.exp);
    end
  endtask

  task automatic idle_bus();
    bus.mfc0 = 0; bus.mtc0 = 0; bus.pc = '0; bus.Rd = '0; bus.wdata = '0;
    bus.exception = 0; bus.eret = 0; bus.cause = '0; bus.irq = '0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle_bus();
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    tick(1);
  endtask

  task automatic wr(input logic [4:0] rd, input logic [31:0] data);
    bus.mtc0 = 1; bus.Rd = rd; bus.wdata = data;
    tick(1);
    bus.mtc0 = 0;
  endtask

  task automatic rd_chk(input string tag, input logic [4:0] rd, input logic [31:0] exp);
    bus.mfc0 = 1; bus.Rd = rd;
    sb_push(tag, exp);
    #1;
    sb_pop(bus.rdata);
    bus.mfc0 = 0;
  endtask

  // sel: 0 irq_pending, 1 exc_addr, 2 status
  task automatic peek(input string tag, input int sel, input logic [31:0] exp);
    logic [31:0] obs;
    sb_push(tag, exp);
    #1;
    case (sel)
      0:       obs = {31'b0, bus.irq_pending};
      1:       obs = bus.exc_addr;
      default: obs = bus.status;
    endcase
    sb_pop(obs);
  endtask

  initial begin
    idle_bus();

    // 1: reset values and register write masks
    do_reset();
    rd_chk("rst_status", 5'd12, 32'h0);
    rd_chk("rst_cause", 5'd13, 32'h0);
    rd_chk("rst_epc", 5'd14, 32'h0);
    rd_chk("rst_compare", 5'd11, 32'hFFFF_FFFF);
    peek("rst_exc_addr", 1, VEC);
    peek("rst_pending", 0, 32'h0);
    peek("rst_status_out", 2, 32'h0);
    wr(5'd13, 32'hFFFF_FFFF);
    rd_chk("cause_sw_mask", 5'd13, 32'h0000_0300);
    wr(5'd12, 32'hFFFF_FFFF);
    rd_chk("status_mask", 5'd12, 32'h0000_FF03);
    wr(5'd5, 32'hDEAD_BEEF);
    rd_chk("unmapped_rd", 5'd5, 32'h0);
    bus.mfc0 = 0; bus.Rd = 5'd12;
    sb_push("rdata_no_mfc0", 32'h0);
    #1;
    sb_pop(bus.rdata);

    // 2: timer match; Count reaches k on the 2k-th edge after the Count write
    do_reset();
    wr(5'd9, 32'h0);
    wr(5'd11, 32'd10);
    wr(5'd12, 32'h0000_8001);
    tick(17);
    rd_chk("count_before", 5'd9, 32'd9);
    rd_chk("ip7_before", 5'd13, 32'h0);
    peek("pend_before", 0, 32'h0);
    tick(1);
    rd_chk("count_match", 5'd9, 32'd10);
    rd_chk("ip7_set", 5'd13, 32'h0000_8000);
    peek("pend_timer", 0, 32'h1);
    tick(2);
    rd_chk("ip7_sticky", 5'd13, 32'h0000_8000);
    wr(5'd11, 32'd100);
    rd_chk("ip7_cleared", 5'd13, 32'h0);
    peek("pend_timer_clr", 0, 32'h0);

    // 3: external interrupt through the synchroniser
    do_reset();
    wr(5'd12, 32'h0000_0401);
    bus.irq = 5'b00001;
    tick(1);
    rd_chk("irq_1cyc", 5'd13, 32'h0);
    peek("pend_1cyc", 0, 32'h0);
    tick(1);
    rd_chk("irq_2cyc", 5'd13, 32'h0000_0400);
    peek("pend_2cyc", 0, 32'h1);
    bus.irq = 5'b10001;
    tick(2);
    rd_chk("irq4_ip6", 5'd13, 32'h0000_4400);
    bus.irq = 5'b00000;
    tick(1);
    rd_chk("irq_drop_1cyc", 5'd13, 32'h0000_4400);
    tick(1);
    rd_chk("irq_drop_2cyc", 5'd13, 32'h0);
    peek("pend_drop", 0, 32'h0);

    // 4: exception entry and eret
    do_reset();
    wr(5'd12, 32'h0000_0401);
    bus.irq = 5'b00001;
    tick(2);
    peek("pend_pre_exc", 0, 32'h1);
    bus.pc = 32'h0040_0100; bus.cause = 5'd8; bus.exception = 1;
    tick(1);
    bus.exception = 0;
    rd_chk("exc_epc", 5'd14, 32'h0040_0100);
    rd_chk("exc_cause", 5'd13, 32'h0000_0420);
    rd_chk("exc_status", 5'd12, 32'h0000_0403);
    peek("exc_status_out", 2, 32'h0000_0403);
    peek("exc_pend_masked", 0, 32'h0);
    peek("exc_addr_idle", 1, VEC);
    bus.eret = 1; bus.exception = 1;
    peek("exc_addr_both", 1, VEC);
    bus.exception = 0;
    peek("eret_exc_addr", 1, 32'h0040_0100);
    tick(1);
    bus.eret = 0;
    rd_chk("eret_status", 5'd12, 32'h0000_0401);
    peek("eret_pend", 0, 32'h1);

    // 5: same-cycle priority, Count load vs prescaler
    do_reset();
    bus.pc = 32'h0040_0200; bus.cause = 5'd13;
    bus.exception = 1; bus.eret = 1;
    bus.mtc0 = 1; bus.Rd = 5'd12; bus.wdata = 32'h0000_FF01;
    tick(1);
    idle_bus();
    rd_chk("prio_status", 5'd12, 32'h0000_0002);
    rd_chk("prio_epc", 5'd14, 32'h0040_0200);
    rd_chk("prio_cause", 5'd13, 32'h0000_0034);
    bus.eret = 1;
    bus.mtc0 = 1; bus.Rd = 5'd12; bus.wdata = 32'h0000_FF01;
    tick(1);
    idle_bus();
    rd_chk("eret_over_mtc0", 5'd12, 32'h0);
    wr(5'd9, 32'd5);
    rd_chk("count_ld_wrap", 5'd9, 32'd5);
    tick(1);
    rd_chk("count_hold", 5'd9, 32'd5);
    tick(1);
    rd_chk("count_inc", 5'd9, 32'd6);
    wr(5'd9, 32'd20);
    tick(1);
    rd_chk("presc_zeroed", 5'd9, 32'd20);
    tick(1);
    rd_chk("presc_wrap_after", 5'd9, 32'd21);

    // 6: Count wrap matching Compare = 0, then reset between edges
    do_reset();
    wr(5'd12, 32'h0000_8001);
    wr(5'd9, 32'hFFFF_FFFF);
    wr(5'd11, 32'h0);
    tick(1);
    rd_chk("wrap_count", 5'd9, 32'h0);
    rd_chk("wrap_ip7", 5'd13, 32'h0000_8000);
    peek("wrap_pend", 0, 32'h1);
    tick(3);
    #4;
    reset = 1'b0;
    peek("arst_status_out", 2, 32'h0);
    peek("arst_pend", 0, 32'h0);
    rd_chk("arst_count", 5'd9, 32'h0);
    rd_chk("arst_compare", 5'd11, 32'hFFFF_FFFF);
    rd_chk("arst_cause", 5'd13, 32'h0);
    peek("arst_exc_addr", 1, VEC);
    @(negedge clk);
    reset = 1'b1;
    tick(1);

    if (sb_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL sb_leftover: got %0d entries expected 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no end of stimulus expected finish");
    $fatal(1, "timeout");
  end
endmodule
